// File: rtl/dram_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dram_fill_arbiter
//  Description : Two-port arbiter for the DRAM-cache fill/write port. Port 0
//                (read-miss fill) has fixed priority. Port 1 (write path) is
//                granted after MAX_CONSEC port-0 grants while it waits.
//                The result drives a one-entry registered output stage.
//  Revision    : 1.0  initial release
// ============================================================================
module dram_fill_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int WDATA_WIDTH = ADDR_WIDTH + DATA_WIDTH,
    parameter int MAX_CONSEC  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rm_valid_i,
    output logic                   rm_ready_o,
    input  logic [WDATA_WIDTH-1:0] rm_wdata_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [WDATA_WIDTH-1:0] wr_wdata_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WDATA_WIDTH-1:0] wdata_o,
    output logic                   src_o,
    output logic [CNT_WIDTH-1:0]   rm_grant_cnt_o,
    output logic [CNT_WIDTH-1:0]   wr_grant_cnt_o
);

    localparam int                  c_STARVE_W = $clog2(MAX_CONSEC + 1);
    localparam logic [c_STARVE_W-1:0] c_MAX    = c_STARVE_W'(MAX_CONSEC);

    logic                   r_valid;
    logic [WDATA_WIDTH-1:0] r_wdata;
    logic                   r_src;
    logic [c_STARVE_W-1:0]  r_starve_cnt;
    logic [CNT_WIDTH-1:0]   r_rm_cnt;
    logic [CNT_WIDTH-1:0]   r_wr_cnt;

    logic w_can_load;
    logic w_cap_hit;
    logic w_prefer_wr;
    logic w_sel_wr;
    logic w_grant_rm;
    logic w_grant_wr;

    // Readiness is held low during reset so nothing is accepted and then lost.
    assign w_can_load  = (!r_valid || ready_i) && !rst;
    assign w_cap_hit   = (r_starve_cnt == c_MAX);
    assign w_prefer_wr = !rm_valid_i || w_cap_hit;
    assign w_sel_wr    = wr_valid_i && w_prefer_wr;

    assign rm_ready_o  = w_can_load && !w_sel_wr;
    assign wr_ready_o  = w_can_load && w_prefer_wr;

    assign w_grant_wr  = wr_valid_i && wr_ready_o;
    assign w_grant_rm  = rm_valid_i && rm_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_wdata <= '0;
            r_src   <= 1'b0;
        end else if (w_grant_wr) begin
            r_valid <= 1'b1;
            r_wdata <= wr_wdata_i;
            r_src   <= 1'b1;
        end else if (w_grant_rm) begin
            r_valid <= 1'b1;
            r_wdata <= rm_wdata_i;
            r_src   <= 1'b0;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Counts port-0 wins that happened while port 1 was waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_wr || !wr_valid_i) begin
            r_starve_cnt <= '0;
        end else if (w_grant_rm && !w_cap_hit) begin
            r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rm_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_grant_rm) begin
                r_rm_cnt <= r_rm_cnt + CNT_WIDTH'(1);
            end
            if (w_grant_wr) begin
                r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign valid_o        = r_valid;
    assign wdata_o        = r_wdata;
    assign src_o          = r_src;
    assign rm_grant_cnt_o = r_rm_cnt;
    assign wr_grant_cnt_o = r_wr_cnt;

endmodule
`default_nettype wire
